// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter using shift-and-add-3.
// The converter handles one input bit per clock, so a BIN_W-bit word takes
// BIN_W SHIFT cycles. It drives the LCD character driver with packed BCD.
// Optional feature macro: ASCII_OUT_EN adds a registered, leading-zero-blanked
// ASCII port. Digit 0 (the units digit) is never blanked.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
`ifdef ASCII_OUT_EN
  ,
  output logic [8*DIGITS-1:0] ascii
`endif
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic [4*DIGITS-1:0] bcd_q,   bcd_d;

  // The result of the current step: the BCD field after the add-3 correction,
  // then shifted left by one bit.
  logic [SR_W-1:0]     corr;
  logic [SR_W-1:0]     shifted;

  // Apply add-3 to every BCD nibble >= 5, then shift the whole accumulator left by one bit.
  // NOTE: every variable written in always_comb is given a default at the top,
  // so no path can leave one unassigned and infer a latch.
  always_comb begin
    corr = shift_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (corr[BIN_W + 4*i +: 4] >= 4'd5) begin
        corr[BIN_W + 4*i +: 4] = corr[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    shifted = {corr[SR_W-2:0], 1'b0};
  end

  // Next-state logic: accept a request in IDLE, step the conversion in SHIFT,
  // and publish the result on the last step.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = {{(4*DIGITS){1'b0}}, bin};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = shifted[SR_W-1 -: 4*DIGITS];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. A reset clears everything, so an
  // interrupted conversion leaves no trace on the outputs.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

`ifdef ASCII_OUT_EN
  // The idle display shows a single "0" in the units position.
  localparam logic [8*DIGITS-1:0] ASCII_RST = {{(DIGITS-1){8'h20}}, 8'h30};

  logic [8*DIGITS-1:0] ascii_q, ascii_d;

  // Convert packed BCD to characters. Scanning from the top digit, each digit
  // above the first non-zero digit becomes a space. The units digit always
  // prints, so a zero value shows as "0".
  function automatic logic [8*DIGITS-1:0] to_ascii(input logic [4*DIGITS-1:0] b);
    logic lead;
    lead     = 1'b1;
    to_ascii = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      if (b[4*i +: 4] != 4'd0 || i == 0) lead = 1'b0;
      to_ascii[8*i +: 8] = lead ? 8'h20 : (8'h30 + {4'h0, b[4*i +: 4]});
    end
  endfunction

  // The characters update on the same edge as bcd and keep their value otherwise.
  always_comb begin
    ascii_d = ascii_q;
    if (done_d) ascii_d = to_ascii(bcd_d);
  end

  // ASCII result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ascii_q <= ASCII_RST;
    else        ascii_q <= ascii_d;
  end

  assign ascii = ascii_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed bench for bin_to_bcd_seq with a queue-based scoreboard.
// Build with ASCII_OUT_EN defined to also check the ascii port.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = 16'h0000;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
`ifdef ASCII_OUT_EN
  logic [39:0] ascii;
`endif

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef ASCII_OUT_EN
    ,
    .ascii (ascii)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic [39:0] asc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   n_exp  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion by repeated division by ten.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference display: the count of significant digits comes from magnitude thresholds.
  function automatic logic [39:0] ref_ascii(input int v);
    logic [39:0] r;
    logic [19:0] b;
    int          nd;
    b  = ref_bcd(v);
    nd = (v >= 10000) ? 5 : (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    for (int i = 0; i < 5; i++) begin
      r[8*i +: 8] = (i < nd) ? (8'h30 + {4'h0, b[4*i +: 4]}) : 8'h20;
    end
    return r;
  endfunction

  task automatic push_exp(input int v);
    exp_t e;
    e.bcd = ref_bcd(v);
    e.asc = ref_ascii(v);
    sb.push_back(e);
    n_exp++;
  endtask

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_done++;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_bcd", bcd, e.bcd);
`ifdef ASCII_OUT_EN
        check("sb_ascii", ascii, e.asc);
`endif
      end
    end
  end

  // Raise start for one accepting edge. The caller must be away from a clock edge.
  task automatic launch(input logic [15:0] v, input bit expect_done);
    start = 1'b1;
    bin   = v;
    if (expect_done) push_exp(int'(v));
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 16'($urandom);
  endtask

  // Count falling edges until done. A pulse that never arrives within the bound fails the latency check.
  task automatic wait_done(input int exp_lat, input string tag);
    int n = 0;
    int busy_cnt = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1;
      else if (busy === 1'b1) busy_cnt++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    // Test 1: reset state.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd, 20'h00000);
`ifdef ASCII_OUT_EN
    check("rst_ascii", ascii, 40'h2020202030);
`endif

    // Test 2: 1234.
    launch(16'h04D2, 1'b1);
    check("busy_after_accept", busy, 1'b1);
    wait_done(17, "t2");
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("bcd_holds", bcd, 20'h01234);

    // Test 3: maximum and zero inputs.
    launch(16'hFFFF, 1'b1);
    wait_done(17, "t3_max");
    launch(16'h0000, 1'b1);
    wait_done(17, "t3_zero");

    // A few other values with different numbers of significant digits.
    for (int k = 0; k < 5; k++) begin
      logic [15:0] v;
      v = (k == 0) ? 16'd9 : (k == 1) ? 16'd99 : 16'($urandom_range(0, 65535));
      @(negedge clk);
      launch(v, 1'b1);
      wait_done(17, "misc");
    end

    // Test 4: a second start during busy is ignored.
    @(negedge clk);
    launch(16'h000A, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    wait_done(12, "t4");
    repeat (20) @(negedge clk);
    check("t4_single_done", n_done, n_exp);

    // Test 5: start in the done cycle is accepted.
    @(negedge clk);
    launch(16'h0005, 1'b1);
    wait_done(17, "t5_first");
    launch(16'h2710, 1'b1);
    wait_done(17, "t5_back2back");

    // Start held high gives repeated conversions every 17 clocks.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd321;
    for (int k = 0; k < 3; k++) push_exp(321);
    for (int k = 0; k < 3; k++) wait_done(17, "held");
    start = 1'b0;

    // Test 6: reset partway through a conversion.
    @(negedge clk);
    launch(16'h04D2, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_bcd", bcd, 20'h00000);
    check("t6_done", done, 1'b0);
`ifdef ASCII_OUT_EN
    check("t6_ascii", ascii, 40'h2020202030);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("t6_busy_after", busy, 1'b0);

    check("done_count", n_done, n_exp);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
